condition_handler: RTL

CONDITION_HANDLER -- requirements
Module: condition_handler

---
 rtl/condition_handler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/condition_handler.sv
// Condition-code evaluator for the ID->EX boundary: forwards EX flags, waits on
// late flag producers, and raises the branch-taken / IF-ID flush sequence.
module condition_handler #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] Cond_in,
  input  logic       Valid_in,
  input  logic       Branch_in,
  input  logic       Link_in,
  input  logic [3:0] CC_in,
  input  logic [3:0] EX_CC_in,
  input  logic       EX_S_in,
  input  logic       Flags_busy_in,
  input  logic       Stall_in,
  output logic       Cond_pass_out,
  output logic       Branch_taken_out,
  output logic       Link_out,
  output logic       Flush_out,
  output logic       Stall_out,
  output logic [1:0] State_dbg_out
);

  typedef enum logic [1:0] {
    EVAL  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pass_q, pass_d;
  logic       taken_q, taken_d;
  logic       link_q, link_d;
  logic       flush_q, flush_d;

  logic [3:0] flags_eff;
  logic       valid_eff;
  logic       needs_flags;
  logic       pass_now;
  logic       take_now;
  logic       eval_fire;

  // Flag order: [3]=Z, [2]=C, [1]=N, [0]=V.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] cc);
    logic z, c, n, v, r;
    z = cc[3];
    c = cc[2];
    n = cc[1];
    v = cc[0];
    case (cond)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = c;
      4'h3:    r = ~c;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = c & ~z;
      4'h9:    r = ~c | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = z | (n != v);
      4'hE:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // While a flush is visible the instruction in ID is wrong-path, so it is ignored.
  assign flags_eff   = EX_S_in ? EX_CC_in : CC_in;
  assign valid_eff   = Valid_in & ~flush_q;
  assign needs_flags = (Cond_in != 4'hE) && (Cond_in != 4'hF);
  assign pass_now    = cond_eval(Cond_in, flags_eff);
  assign take_now    = Branch_in & pass_now;

  // WAIT only exists for a valid instruction, so its release evaluates as valid.
  assign eval_fire = ~Stall_in &
                     (((state_q == EVAL) & valid_eff & ~(Flags_busy_in & needs_flags)) |
                      ((state_q == WAIT) & ~Flags_busy_in));

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= EVAL;
      cnt_q   <= 2'd0;
      pass_q  <= 1'b0;
      taken_q <= 1'b0;
      link_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      taken_q <= taken_d;
      link_q  <= link_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    taken_d = taken_q;
    link_d  = link_q;
    flush_d = flush_q;
    if (!Stall_in) begin
      pass_d  = 1'b0;
      taken_d = 1'b0;
      link_d  = 1'b0;
      flush_d = 1'b0;
      case (state_q)
        EVAL: begin
          if (valid_eff && Flags_busy_in && needs_flags) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (!Flags_busy_in) begin
            state_d = EVAL;
          end
        end
        FLUSH: begin
          if (cnt_q != 2'd0) begin
            flush_d = 1'b1;
            cnt_d   = cnt_q - 2'd1;
          end else begin
            state_d = EVAL;
          end
        end
        default: state_d = EVAL;
      endcase
      if (eval_fire) begin
        pass_d  = pass_now;
        taken_d = take_now;
        link_d  = take_now & Link_in;
        flush_d = take_now;
        if (take_now) begin
          cnt_d   = CNT_LOAD;
          state_d = (FLUSH_CYCLES > 1) ? FLUSH : EVAL;
        end
      end
    end
  end

  always_comb begin
    Stall_out = ~Stall_in &
                (((state_q == EVAL) & valid_eff & Flags_busy_in & needs_flags) |
                 ((state_q == WAIT) & Flags_busy_in));
    Cond_pass_out    = pass_q;
    Branch_taken_out = taken_q;
    Link_out         = link_q;
    Flush_out        = flush_q;
    State_dbg_out    = state_q;
  end

endmodule
